// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_pkg
// Purpose  : Shared definitions for the multicycle MIPS control FSM: opcode
//            values, FSM state encoding, and the mux/ALU select codes that
//            the controller drives into the datapath.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  // MIPS opcode field values (6-bit native width; zero-extended by users)
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] J     = 6'b000010;

  // alu_op codes consumed by the separate ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_src_b mux codes
  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // pc_src mux codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    RST     = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXEC    = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JUMP    = 4'd12,
    ILLEGAL = 4'd13,
    HALT    = 4'd14
  } state_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Moore control FSM for a multicycle MIPS datapath. Sequences one
//            instruction over several cycles on a shared memory and ALU, with
//            a memory-ready wait handshake, illegal-opcode trap and a retire
//            pulse in the last cycle of every instruction.
// Ports    :
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   opcode     in   IR opcode field, only looked at in DECODE
//   mem_ready  in   memory completes current access this cycle
//   pc_write   out  unconditional PC load
//   branch     out  PC load qualified by ALU zero
//   iord       out  memory address mux (0 = PC, 1 = ALUOut)
//   mem_read   out  memory read request
//   mem_write  out  memory write request
//   ir_write   out  instruction register load
//   reg_dst    out  write-register mux (1 = rd, 0 = rt)
//   mem_to_reg out  write-data mux (1 = MDR)
//   reg_write  out  register file write enable
//   alu_src_a  out  ALU A mux (0 = PC, 1 = rs)
//   alu_src_b  out  ALU B mux (rt / 4 / imm / imm<<2)
//   alu_op     out  ALU decoder control (add / sub / funct)
//   pc_src     out  PC mux (ALU / ALUOut / jump target)
//   illegal_op out  one-cycle pulse on an unsupported opcode
//   retire     out  one-cycle pulse in the final cycle of an instruction
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W     = 6,
  parameter bit          MEM_WAIT_EN  = 1'b1,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                branch,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic                illegal_op,
  output logic                retire
);

  localparam logic [OPCODE_W-1:0] c_op_rtype = OPCODE_W'(RTYPE);
  localparam logic [OPCODE_W-1:0] c_op_lw    = OPCODE_W'(LW);
  localparam logic [OPCODE_W-1:0] c_op_sw    = OPCODE_W'(SW);
  localparam logic [OPCODE_W-1:0] c_op_beq   = OPCODE_W'(BEQ);
  localparam logic [OPCODE_W-1:0] c_op_addi  = OPCODE_W'(ADDI);
  localparam logic [OPCODE_W-1:0] c_op_j     = OPCODE_W'(J);

  state_t state_q, state_d;
  // LW and SW share MEMADR; remember which one DECODE saw so the opcode
  // input is free to change after DECODE.
  logic   is_sw_q, is_sw_d;
  logic   w_ready;

  // With waiting disabled every memory access completes in one cycle.
  if (MEM_WAIT_EN) begin : g_mem_wait
    assign w_ready = mem_ready;
  end else begin : g_mem_nowait
    assign w_ready = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_sw_d    = is_sw_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_RT;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    illegal_op = 1'b0;
    retire     = 1'b0;

    case (state_q)
      RST: state_d = FETCH;

      FETCH: begin
        // PC+4 and IR load commit only on the cycle memory delivers
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write  = w_ready;
        pc_write  = w_ready;
        if (w_ready) state_d = DECODE;
      end

      DECODE: begin
        // Speculative branch target PC + (imm << 2)
        alu_src_b = ALUB_IMM_SH;
        is_sw_d   = (opcode == c_op_sw);
        if (opcode == c_op_rtype)                         state_d = EXEC;
        else if ((opcode == c_op_lw) || (opcode == c_op_sw)) state_d = MEMADR;
        else if (opcode == c_op_beq)                      state_d = BRANCH;
        else if (opcode == c_op_addi)                     state_d = ADDIEX;
        else if (opcode == c_op_j)                        state_d = JUMP;
        else                                              state_d = ILLEGAL;
      end

      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = is_sw_q ? MEMWR : MEMRD;
      end

      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (w_ready) state_d = MEMWB;
      end

      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end

      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = w_ready;
        if (w_ready) state_d = FETCH;
      end

      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end

      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end

      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end

      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d   = ADDIWB;
      end

      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end

      JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = FETCH;
      end

      ILLEGAL: begin
        // PC already advanced in FETCH, so skipping needs no PC update
        illegal_op = 1'b1;
        state_d    = ILLEGAL_HALT ? HALT : FETCH;
      end

      HALT: state_d = HALT;

      default: state_d = RST;
    endcase
  end

endmodule
`default_nettype wire
